// File: rtl/fpu_wb_queue.sv
// fpu_wb_queue
//   FIFO of completed FPU results sitting between the FPU output register and
//   the writeback arbiter. Holds up to DEPTH entries, hands them to writeback
//   in order over a valid/ready handshake, and produces the per-result
//   fcsr.fflags write strobe plus a pending flag that CSR reads of fflags use.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush_i             synchronous flush; empties the queue
//   fpu_reg_we_i        FPU result present
//   fpu_reg_waddr_i     result destination register
//   fpu_reg_wdata_i     result data
//   fpu_commit_id_i     result commit id
//   fpu_fcsr_we_i       result carries non-zero exception flags
//   fpu_fcsr_fflags_i   exception flags {NV,DZ,OF,UF,NX}
//   fpu_wb_ready_o      queue can accept a result (not full)
//   wb_valid_o          head entry valid
//   wb_waddr_o          head destination register
//   wb_wdata_o          head data
//   wb_commit_id_o      head commit id
//   wb_ready_i          writeback accepts the head entry
//   fcsr_we_o           one-cycle fflags write strobe, cycle after a pop
//   fcsr_fflags_o       flags to OR into fcsr.fflags
//   fflags_pending_o    a queued or in-flight result still has to write fflags
//   count_o             occupancy
module fpu_wb_queue #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CID_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     fpu_reg_we_i,
    input  logic [ADDR_W-1:0]        fpu_reg_waddr_i,
    input  logic [DATA_W-1:0]        fpu_reg_wdata_i,
    input  logic [CID_W-1:0]         fpu_commit_id_i,
    input  logic                     fpu_fcsr_we_i,
    input  logic [4:0]               fpu_fcsr_fflags_i,
    output logic                     fpu_wb_ready_o,
    output logic                     wb_valid_o,
    output logic [ADDR_W-1:0]        wb_waddr_o,
    output logic [DATA_W-1:0]        wb_wdata_o,
    output logic [CID_W-1:0]         wb_commit_id_o,
    input  logic                     wb_ready_i,
    output logic                     fcsr_we_o,
    output logic [4:0]               fcsr_fflags_o,
    output logic                     fflags_pending_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [CID_W-1:0]  cid;
        logic              fcsr_we;
        logic [4:0]        fflags;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic            queued_pending;

    // Ready depends on occupancy only: a full queue never accepts, even when
    // writeback is popping in the same cycle.
    assign fpu_wb_ready_o = (count < CW'(DEPTH));
    assign wb_valid_o     = (count != '0);
    assign push           = fpu_reg_we_i & fpu_wb_ready_o;
    assign pop            = wb_valid_o & wb_ready_i;

    assign head           = mem[rd_ptr];
    assign wb_waddr_o     = head.waddr;
    assign wb_wdata_o     = head.wdata;
    assign wb_commit_id_o = head.cid;
    assign count_o        = count;

    // Scan the occupied slots, starting from the head, for a pending flag write.
    always_comb begin
        queued_pending = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) && mem[rd_ptr + PW'(i)].fcsr_we) begin
                queued_pending = 1'b1;
            end
        end
    end

    // The strobe in flight keeps pending high until the fflags write lands.
    assign fflags_pending_o = queued_pending | fcsr_we_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            fcsr_we_o     <= 1'b0;
            fcsr_fflags_o <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            fcsr_we_o <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{waddr:   fpu_reg_waddr_i,
                                 wdata:   fpu_reg_wdata_i,
                                 cid:     fpu_commit_id_i,
                                 fcsr_we: fpu_fcsr_we_i,
                                 fflags:  fpu_fcsr_fflags_i};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Flags of an entry without fcsr_we are ignored, so the flag
            // output only moves when a real flag write is issued.
            fcsr_we_o <= pop & head.fcsr_we;
            if (pop && head.fcsr_we) begin
                fcsr_fflags_o <= head.fflags;
            end
        end
    end

endmodule

// File: tb/tb_fpu_wb_queue.sv
module tb_fpu_wb_queue;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        fpu_reg_we_i;
    logic [4:0]  fpu_reg_waddr_i;
    logic [31:0] fpu_reg_wdata_i;
    logic [3:0]  fpu_commit_id_i;
    logic        fpu_fcsr_we_i;
    logic [4:0]  fpu_fcsr_fflags_i;
    logic        fpu_wb_ready_o;
    logic        wb_valid_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic [3:0]  wb_commit_id_o;
    logic        wb_ready_i;
    logic        fcsr_we_o;
    logic [4:0]  fcsr_fflags_o;
    logic        fflags_pending_o;
    logic [1:0]  count_o;

    int total = 0;
    int bad   = 0;

    fpu_wb_queue #(.DEPTH(2), .DATA_W(32), .ADDR_W(5), .CID_W(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush_i           (flush_i),
        .fpu_reg_we_i      (fpu_reg_we_i),
        .fpu_reg_waddr_i   (fpu_reg_waddr_i),
        .fpu_reg_wdata_i   (fpu_reg_wdata_i),
        .fpu_commit_id_i   (fpu_commit_id_i),
        .fpu_fcsr_we_i     (fpu_fcsr_we_i),
        .fpu_fcsr_fflags_i (fpu_fcsr_fflags_i),
        .fpu_wb_ready_o    (fpu_wb_ready_o),
        .wb_valid_o        (wb_valid_o),
        .wb_waddr_o        (wb_waddr_o),
        .wb_wdata_o        (wb_wdata_o),
        .wb_commit_id_o    (wb_commit_id_o),
        .wb_ready_i        (wb_ready_i),
        .fcsr_we_o         (fcsr_we_o),
        .fcsr_fflags_o     (fcsr_fflags_o),
        .fflags_pending_o  (fflags_pending_o),
        .count_o           (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data and commit id are fixed functions of the destination, so the head
    // fields can be predicted from the expected destination alone.
    function automatic logic [31:0] dw(input logic [4:0] a);
        return (a == 5'd5) ? 32'h3F80_0000 : {16'hBEEF, 11'h0, a};
    endfunction

    function automatic logic [3:0] dc(input logic [4:0] a);
        return (a == 5'd5) ? 4'd2 : a[3:0];
    endfunction

    typedef struct {
        logic       flush;
        logic       we;
        logic [4:0] a;
        logic       fwe;
        logic [4:0] ffl;
        logic       rdy;
        logic       ev;
        logic [4:0] eh;
        logic [1:0] ec;
        logic       er;
        logic       efo;
        logic [4:0] effl;
        logic       ep;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic fl, we, input logic [4:0] a, input logic fwe,
                                input logic [4:0] ffl, input logic rdy, ev,
                                input logic [4:0] eh, input logic [1:0] ec,
                                input logic er, efo, input logic [4:0] effl, input logic ep);
        vec_t v;
        v.flush = fl; v.we = we; v.a = a; v.fwe = fwe; v.ffl = ffl; v.rdy = rdy;
        v.ev = ev; v.eh = eh; v.ec = ec; v.er = er; v.efo = efo; v.effl = effl; v.ep = ep;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, we, input logic [4:0] a, input logic fwe,
                         input logic [4:0] ffl, input logic rdy);
        flush_i           = fl;
        fpu_reg_we_i      = we;
        fpu_reg_waddr_i   = a;
        fpu_reg_wdata_i   = dw(a);
        fpu_commit_id_i   = dc(a);
        fpu_fcsr_we_i     = fwe;
        fpu_fcsr_fflags_i = ffl;
        wb_ready_i        = rdy;
    endtask

    task automatic chk_head(input string nm, input logic [4:0] eh);
        chk({nm, ".waddr"}, 32'(wb_waddr_o), 32'(eh));
        chk({nm, ".wdata"}, wb_wdata_o, dw(eh));
        chk({nm, ".cid"}, 32'(wb_commit_id_o), 32'(dc(eh)));
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, ".count"}, 32'(count_o), 32'd0);
        chk({nm, ".valid"}, 32'(wb_valid_o), 32'd0);
        chk({nm, ".ready"}, 32'(fpu_wb_ready_o), 32'd1);
        chk({nm, ".fcsr_we"}, 32'(fcsr_we_o), 32'd0);
        chk({nm, ".fflags"}, 32'(fcsr_fflags_o), 32'd0);
        chk({nm, ".pending"}, 32'(fflags_pending_o), 32'd0);
        chk({nm, ".waddr"}, 32'(wb_waddr_o), 32'd0);
        chk({nm, ".wdata"}, wb_wdata_o, 32'd0);
        chk({nm, ".cid"}, 32'(wb_commit_id_o), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #12;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        //      fl  we  a      fwe  ffl        rdy  ev   eh     ec    er   efo  effl       ep
        // first push, then flagged entry behind an unflagged one
        tbl.push_back(mk(0, 1, 5'd5,  0, 5'b00000, 0,   1, 5'd5,  2'd1, 1, 0, 5'b00000, 0));
        tbl.push_back(mk(0, 1, 5'd6,  1, 5'b00001, 0,   1, 5'd5,  2'd2, 0, 0, 5'b00000, 1));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'b00000, 1,   1, 5'd6,  2'd1, 1, 0, 5'b00000, 1));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'b00000, 1,   0, 5'd0,  2'd0, 1, 1, 5'b00001, 1));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'b00000, 1,   0, 5'd0,  2'd0, 1, 0, 5'b00000, 0));
        // back-pressure: three results, third held until a pop frees a slot
        tbl.push_back(mk(0, 1, 5'd1,  0, 5'b00000, 0,   1, 5'd1,  2'd1, 1, 0, 5'b00000, 0));
        tbl.push_back(mk(0, 1, 5'd2,  0, 5'b00000, 0,   1, 5'd1,  2'd2, 0, 0, 5'b00000, 0));
        tbl.push_back(mk(0, 1, 5'd3,  0, 5'b00000, 0,   1, 5'd1,  2'd2, 0, 0, 5'b00000, 0));
        tbl.push_back(mk(0, 1, 5'd3,  0, 5'b00000, 1,   1, 5'd2,  2'd1, 1, 0, 5'b00000, 0));
        tbl.push_back(mk(0, 1, 5'd3,  0, 5'b00000, 1,   1, 5'd3,  2'd1, 1, 0, 5'b00000, 0));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'b00000, 1,   0, 5'd0,  2'd0, 1, 0, 5'b00000, 0));
        // flush while full with flagged entries and a head pop offered
        tbl.push_back(mk(0, 1, 5'd7,  1, 5'b10000, 0,   1, 5'd7,  2'd1, 1, 0, 5'b00000, 1));
        tbl.push_back(mk(0, 1, 5'd8,  1, 5'b01000, 0,   1, 5'd7,  2'd2, 0, 0, 5'b00000, 1));
        tbl.push_back(mk(1, 1, 5'd9,  0, 5'b00000, 1,   0, 5'd0,  2'd0, 1, 0, 5'b00000, 0));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'b00000, 1,   0, 5'd0,  2'd0, 1, 0, 5'b00000, 0));
        // flush drops a push that the queue would otherwise accept
        tbl.push_back(mk(0, 1, 5'd10, 0, 5'b00000, 0,   1, 5'd10, 2'd1, 1, 0, 5'b00000, 0));
        tbl.push_back(mk(1, 1, 5'd11, 1, 5'b00010, 1,   0, 5'd0,  2'd0, 1, 0, 5'b00000, 0));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'b00000, 1,   0, 5'd0,  2'd0, 1, 0, 5'b00000, 0));
        // strobe carries only the flagged entry's flags; unflagged one gives none
        tbl.push_back(mk(0, 1, 5'd12, 1, 5'b00100, 0,   1, 5'd12, 2'd1, 1, 0, 5'b00000, 1));
        tbl.push_back(mk(0, 1, 5'd13, 0, 5'b11111, 1,   1, 5'd13, 2'd1, 1, 1, 5'b00100, 1));
        tbl.push_back(mk(0, 0, 5'd0,  0, 5'b00000, 1,   0, 5'd0,  2'd0, 1, 0, 5'b00000, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            string nm;
            nm = $sformatf("row%0d", i);
            drive(tbl[i].flush, tbl[i].we, tbl[i].a, tbl[i].fwe, tbl[i].ffl, tbl[i].rdy);
            @(posedge clk); #1;
            chk({nm, ".valid"}, 32'(wb_valid_o), 32'(tbl[i].ev));
            if (tbl[i].ev) chk_head(nm, tbl[i].eh);
            chk({nm, ".count"}, 32'(count_o), 32'(tbl[i].ec));
            chk({nm, ".ready"}, 32'(fpu_wb_ready_o), 32'(tbl[i].er));
            chk({nm, ".fcsr_we"}, 32'(fcsr_we_o), 32'(tbl[i].efo));
            if (tbl[i].efo) chk({nm, ".fflags"}, 32'(fcsr_fflags_o), 32'(tbl[i].effl));
            chk({nm, ".pending"}, 32'(fflags_pending_o), 32'(tbl[i].ep));
        end

        // sustained push+pop at occupancy 1
        drive(1'b0, 1'b1, 5'd14, 1'b0, 5'd0, 1'b0);
        @(posedge clk); #1;
        chk("stream.prime.count", 32'(count_o), 32'd1);
        chk_head("stream.prime", 5'd14);
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 5'(15 + k), 1'b0, 5'd0, 1'b1);
            @(posedge clk); #1;
            chk($sformatf("stream%0d.count", k), 32'(count_o), 32'd1);
            chk_head($sformatf("stream%0d", k), 5'(15 + k));
        end
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        @(posedge clk); #1;
        chk("stream.drain.count", 32'(count_o), 32'd0);
        chk("stream.drain.valid", 32'(wb_valid_o), 32'd0);

        // asynchronous reset mid-cycle with two flagged entries queued
        drive(1'b0, 1'b1, 5'd20, 1'b1, 5'b00011, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 5'd21, 1'b1, 5'b00101, 1'b0);
        @(posedge clk); #1;
        chk("arst.pre.count", 32'(count_o), 32'd2);
        chk("arst.pre.pending", 32'(fflags_pending_o), 32'd1);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("arst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst.post.fcsr_we", 32'(fcsr_we_o), 32'd0);
        chk("arst.post.valid", 32'(wb_valid_o), 32'd0);
        chk("arst.post.count", 32'(count_o), 32'd0);
        chk("arst.post.pending", 32'(fflags_pending_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_wb_queue.md
# fpu_wb_queue

Result queue between the FPU execution unit and the integer/float writeback arbiter. Accepts one completed FPU result per cycle (destination, data, commit id, exception flags), buffers up to DEPTH entries in FIFO order, and presents them to writeback with a valid/ready handshake. It also generates the per-result FCSR fflags write and a pending indication for CSR reads. Its input-side ready drives the FPU's `wb_ready_i`, so writeback back-pressure no longer stalls the FPU output register directly.

## Interface
- DEPTH, 2, number of entries; power of two, ≥2
- DATA_W, `FREG_DATA_WIDTH, result data width
- ADDR_W, `REG_ADDR_WIDTH, destination register address width
- CID_W, `COMMIT_ID_WIDTH, commit id width

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush, empties queue
- fpu_reg_we_i  in  1  input valid (FPU result present)
- fpu_reg_waddr_i  in  ADDR_W  destination register
- fpu_reg_wdata_i  in  DATA_W  result data
- fpu_commit_id_i  in  CID_W  commit id
- fpu_fcsr_we_i  in  1  result carries non-zero flags
- fpu_fcsr_fflags_i  in  5  exception flags {NV,DZ,OF,UF,NX}
- fpu_wb_ready_o  out  1  input ready (= not full)
- wb_valid_o  out  1  head entry valid
- wb_waddr_o  out  ADDR_W  head destination
- wb_wdata_o  out  DATA_W  head data
- wb_commit_id_o  out  CID_W  head commit id
- wb_ready_i  in  1  writeback accepts head
- fcsr_we_o  out  1  one-cycle fflags write strobe
- fcsr_fflags_o  out  5  flags to OR into fcsr.fflags
- fflags_pending_o  out  1  some queued entry has fcsr_we set
- count_o  out  $clog2(DEPTH)+1  occupancy

## Operation
- push = fpu_reg_we_i & fpu_wb_ready_o; pop = wb_valid_o & wb_ready_i.
- fpu_wb_ready_o = (count < DEPTH); combinational from count only, never from wb_ready_i (no full-queue bypass).
- Storage: DEPTH-entry array of {waddr, wdata, cid, fcsr_we, fflags}; rd_ptr/wr_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH naturally; separate count register.
- Push writes entry at wr_ptr, wr_ptr+1. Pop advances rd_ptr. Push and pop in the same cycle: both occur, count unchanged (legal at any non-full occupancy, including count=1).
- wb_valid_o = (count != 0); head fields = entry[rd_ptr] (combinational read of registered storage).
- On pop: fcsr_we_o asserted next cycle iff popped entry's fcsr_we=1; fcsr_fflags_o = popped entry's fflags (registered, holds last value when strobe low). Flags are never merged across entries.
- fflags_pending_o = OR of fcsr_we over valid entries, OR fcsr_we_o registered strobe still in flight (so CSR read of fflags waits until the write lands).
- flush_i: count←0, pointers←0, fcsr_we_o←0; push and pop in the flush cycle are dropped. fpu_wb_ready_o stays as computed from count in that cycle.
- Flag bits of an entry with fcsr_we=0 are stored but ignored.

## Timing
- Reset (rst_n low, async): count_o=0, pointers=0, wb_valid_o=0, fpu_wb_ready_o=1, fcsr_we_o=0, fcsr_fflags_o=0, fflags_pending_o=0; wb_* data outputs = 0 (storage reset). Reset mid-operation discards all entries.
- Latency: push in cycle N → wb_valid_o=1 in cycle N+1 with that entry at head. No same-cycle pass-through.
- Throughput: one push and one pop per cycle sustained.
- Pop in cycle N → fcsr_we_o high in cycle N+1 only, one cycle.
- Full (count=DEPTH): fpu_wb_ready_o=0; input held by the FPU until a pop frees an entry; ready rises in the cycle after that pop.
- Empty: wb_valid_o=0; wb_ready_i ignored.

## Test plan
- Reset → all outputs at reset values listed; push {waddr=5, wdata=0x3F800000, cid=2, fcsr_we=0} → next cycle wb_valid_o=1, wb_waddr_o=5, wb_wdata_o=0x3F800000, count_o=1.
- DEPTH=2, wb_ready_i=0, three back-to-back results → two accepted, fpu_wb_ready_o=0 with count_o=2; third held until one pop, then accepted; order of popped waddr 1,2,3.
- Continuous push+pop at count=1 for 10 cycles → count_o stays 1, data order preserved, no loss or duplicate.
- Entry with fcsr_we=1, fflags=5'b00001 queued behind one with fcsr_we=0 → fflags_pending_o=1 from the cycle after push; fcsr_we_o pulses once with 00001 in the cycle after its pop; pending drops the cycle after that.
- flush_i with count=2 and a simultaneous push → next cycle count_o=0, wb_valid_o=0, fcsr_we_o=0, pushed entry absent.
- rst_n asserted asynchronously mid-cycle with count=2 → outputs return to reset values immediately, no fcsr_we_o pulse after release.
